// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

  localparam int KEY_W    = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1110;

  typedef enum logic [1:0] {IDLE, PRESSED, BLOCKED} state_e;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_kind_e;

  typedef struct packed {
    scan_kind_e       kind;
    logic [KEY_W-1:0] code;
  } scan_result_t;

  // Active-low one-hot column drive for a column index.
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] idx);
    return ~(NUM_COLS'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - full-scan candidate tracking with a saturating agreement counter
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             scan_end_i,
  input  logic [1:0]       result_kind_i,
  input  logic [KEY_W-1:0] result_code_i,
  output logic [1:0]       cand_kind_o,
  output logic [KEY_W-1:0] cand_code_o,
  output logic             stable_o
);

  localparam int            CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  scan_result_t  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match;

  always_comb begin
    match    = (result_kind_i == cand_q.kind) && (result_code_i == cand_q.code);
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_o = 1'b0;
    if (scan_end_i) begin
      if (!match) begin
        cand_d = '{kind: scan_kind_e'(result_kind_i), code: result_code_i};
        cnt_d  = CW'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
      // Strobe only on the transition into agreement, never while saturated.
      stable_o = (cnt_d == CNT_MAX) && (!match || (cnt_q != CNT_MAX));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cand_q <= '{kind: NONE, code: '0};
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cand_kind_o = cand_d.kind;
  assign cand_code_o = cand_d.code;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and press-event generation
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keyin,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int            TW        = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick, scan_end;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;

  logic [NUM_ROWS-1:0] col_hits;
  logic [2:0]          col_cnt, acc_sum;
  logic [1:0]          first_row;
  logic [1:0]          acc_cnt_q, acc_cnt_d, scan_cnt;
  logic [KEY_W-1:0]    acc_code_q, acc_code_d, scan_code;
  scan_result_t        scan_res;

  logic [1:0]          cand_kind;
  logic [KEY_W-1:0]    cand_code;
  logic                stable;

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    keyin_q, keyin_d;
  logic                valid_q, valid_d;
  logic                held_q, held_d;
  logic                multi_q, multi_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    scan_end   = tick && (col_idx_q == 2'(NUM_COLS - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    col_idx_d  = tick ? col_idx_q + 2'd1 : col_idx_q;
    col_d      = tick ? col_drive(col_idx_d) : col_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tick_cnt_q <= '0;
      col_idx_q  <= '0;
      col_q      <= COL_IDLE;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
    end
  end

  // Descending loop so the lowest pressed row wins within the column.
  always_comb begin
    col_hits  = ~row_sync_q;
    col_cnt   = '0;
    first_row = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (col_hits[r]) first_row = 2'(r);
      col_cnt = col_cnt + 3'(col_hits[r]);
    end
    acc_sum   = 3'(acc_cnt_q) + col_cnt;
    scan_cnt  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
    scan_code = ((acc_cnt_q == 2'd0) && (col_hits != '0)) ? {first_row, col_idx_q} : acc_code_q;

    scan_res = '{kind: NONE, code: '0};
    if (scan_cnt == 2'd1) begin
      scan_res = '{kind: SINGLE, code: scan_code};
    end else if (scan_cnt == 2'd2) begin
      scan_res = '{kind: MULTI, code: '0};
    end

    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (scan_end) begin
      acc_cnt_d  = '0;
      acc_code_d = '0;
    end else if (tick) begin
      acc_cnt_d  = scan_cnt;
      acc_code_d = scan_code;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
    end else begin
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i        (CLK),
    .rst_ni       (RST),
    .scan_end_i   (scan_end),
    .result_kind_i(scan_res.kind),
    .result_code_i(scan_res.code),
    .cand_kind_o  (cand_kind),
    .cand_code_o  (cand_code),
    .stable_o     (stable)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      keyin_q <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      keyin_q <= keyin_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      multi_q <= multi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stable) begin
      case (state_q)
        IDLE: begin
          if (cand_kind == SINGLE)     state_d = PRESSED;
          else if (cand_kind == MULTI) state_d = BLOCKED;
        end
        PRESSED: begin
          if (cand_kind == NONE)       state_d = IDLE;
          else if (cand_kind == MULTI) state_d = BLOCKED;
        end
        BLOCKED: begin
          if (cand_kind == NONE)       state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Rollover in PRESSED and singles in BLOCKED are deliberately ignored.
  always_comb begin
    keyin_d = keyin_q;
    valid_d = 1'b0;
    held_d  = held_q;
    multi_d = multi_q;
    if (stable) begin
      case (state_q)
        IDLE: begin
          if (cand_kind == SINGLE) begin
            keyin_d = cand_code;
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else if (cand_kind == MULTI) begin
            multi_d = 1'b1;
          end
        end
        PRESSED: begin
          if (cand_kind == NONE) begin
            held_d = 1'b0;
          end else if (cand_kind == MULTI) begin
            held_d  = 1'b0;
            multi_d = 1'b1;
          end
        end
        BLOCKED: begin
          if (cand_kind == NONE) multi_d = 1'b0;
        end
        default: begin
          held_d  = 1'b0;
          multi_d = 1'b0;
        end
      endcase
    end
  end

  assign col_out   = col_q;
  assign keyin     = keyin_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed and randomized checks of keypad_scanner against a scan-level model
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_CYC = SCAN_DIV * 4;

  localparam int K_NONE = 0, K_SINGLE = 1, K_MULTI = 2;
  localparam int S_IDLE = 0, S_PRESSED = 1, S_BLOCKED = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  row_in, col_out, keyin;
  logic        key_valid, key_held, multi_key;
  logic [15:0] keys = '0;

  int checks = 0, errors = 0, pulses = 0, m_pulses = 0;

  int         m_last_kind, m_last_code, m_run, m_state;
  logic [3:0] e_keyin;
  logic       e_valid, e_held, e_multi;

  always #5 CLK = ~CLK;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .row_in   (row_in),
    .col_out  (col_out),
    .keyin    (keyin),
    .key_valid(key_valid),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  // Passive matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge CLK) if (RST && key_valid) pulses++;

  task automatic model_reset();
    m_last_kind = K_NONE;
    m_last_code = 0;
    m_run       = 0;
    m_state     = S_IDLE;
    e_keyin     = 4'h0;
    e_valid     = 1'b0;
    e_held      = 1'b0;
    e_multi     = 1'b0;
  endtask

  task automatic model_scan(input logic [15:0] m);
    int n;
    int code;
    int kind;
    n    = $countones(m);
    code = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) code = i;
    kind = (n == 0) ? K_NONE : ((n == 1) ? K_SINGLE : K_MULTI);
    if (kind != K_SINGLE) code = 0;
    e_valid = 1'b0;
    if (kind == m_last_kind && code == m_last_code) begin
      m_run++;
    end else begin
      m_last_kind = kind;
      m_last_code = code;
      m_run       = 1;
    end
    if (m_run == DEB) begin
      case (m_state)
        S_IDLE: begin
          if (kind == K_SINGLE) begin
            e_keyin = 4'(code);
            e_valid = 1'b1;
            e_held  = 1'b1;
            m_state = S_PRESSED;
            m_pulses++;
          end else if (kind == K_MULTI) begin
            e_multi = 1'b1;
            m_state = S_BLOCKED;
          end
        end
        S_PRESSED: begin
          if (kind == K_NONE) begin
            e_held  = 1'b0;
            m_state = S_IDLE;
          end else if (kind == K_MULTI) begin
            e_held  = 1'b0;
            e_multi = 1'b1;
            m_state = S_BLOCKED;
          end
        end
        default: begin
          if (kind == K_NONE) begin
            e_multi = 1'b0;
            m_state = S_IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/keyin"},     keyin,              e_keyin);
    check({tag, "/key_valid"}, {3'b000, key_valid}, {3'b000, e_valid});
    check({tag, "/key_held"},  {3'b000, key_held},  {3'b000, e_held});
    check({tag, "/multi_key"}, {3'b000, multi_key}, {3'b000, e_multi});
  endtask

  task automatic run_scan(input logic [15:0] m, input string tag);
    keys = m;
    repeat (SCAN_CYC) @(posedge CLK);
    #1;
    model_scan(m);
    check_outputs(tag);
  endtask

  function automatic logic [15:0] key(input int k);
    return 16'(1) << k;
  endfunction

  initial begin
    logic [15:0] m;
    int a, b, kind, hold;

    model_reset();
    RST  = 1'b0;
    keys = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset/col_out", col_out, 4'b1110);
    check_outputs("reset");

    @(negedge CLK);
    RST = 1'b1;
    for (int k = 1; k <= 2 * SCAN_CYC; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("colseq%0d", k), col_out, ~(4'b0001 << ((k / SCAN_DIV) % 4)));
    end
    model_scan('0);
    model_scan('0);

    for (int i = 0; i < 3; i++) run_scan(key(9), "single_press");
    for (int i = 0; i < 3; i++) run_scan('0, "single_release");

    for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? key(6) : '0, "bounce_toggle");
    for (int i = 0; i < 3; i++) run_scan(key(6), "bounce_hold");
    for (int i = 0; i < 3; i++) run_scan('0, "bounce_release");

    for (int i = 0; i < 3; i++) run_scan(key(0) | key(15), "multi_press");
    for (int i = 0; i < 3; i++) run_scan('0, "multi_release");
    for (int i = 0; i < 3; i++) run_scan(key(2), "after_multi");
    for (int i = 0; i < 3; i++) run_scan('0, "after_multi_release");

    for (int i = 0; i < 3; i++) run_scan(key(5), "roll_first");
    for (int i = 0; i < 3; i++) run_scan(key(10), "roll_second");
    for (int i = 0; i < 3; i++) run_scan('0, "roll_release");
    for (int i = 0; i < 3; i++) run_scan(key(10), "roll_repress");
    for (int i = 0; i < 3; i++) run_scan('0, "roll_release2");

    for (int i = 0; i < 3; i++) run_scan(key(3), "areset_press");
    repeat (5) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check("areset/col_out", col_out, 4'b1110);
    check_outputs("areset");
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) run_scan(key(3), "areset_held");
    for (int i = 0; i < 2; i++) run_scan('0, "areset_release");

    for (int it = 0; it < 50; it++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      m    = (kind == 0) ? '0 : ((kind == 1) ? key(a) : (key(a) | key(b)));
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) run_scan(m, $sformatf("rand%0d", it));
    end

    @(negedge CLK);
    checks++;
    assert (pulses == m_pulses) else begin
      errors++;
      $error("FAIL pulse_count observed=%0d expected=%0d", pulses, m_pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 passive matrix keypad and produces the debounced 4-bit key code consumed by the game logic on keyin/enter. It drives one column low at a time, samples the active-low rows, rejects bounce and multi-key presses, and emits one press event per physical key press. It sits between the board keypad pins and the game controller.

Parameters:
SCAN_DIV, 25000, CLK cycles each column is driven before sampling and advancing; must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full scans required before a result is accepted; must be >= 1

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-low
row_in  input  4  keypad rows, active-low, pulled up externally
col_out  output  4  keypad column drive, active-low, one-hot-low
keyin  output  4  code of last accepted key = {row_idx[1:0], col_idx[1:0]}
key_valid  output  1  one-CLK pulse when a new key press is accepted
key_held  output  1  high while the accepted key remains stably pressed
multi_key  output  1  high while a stable multi-key press is present

Behaviour:
- Reset, asynchronous on RST low:
  - col_out=4'b1110, keyin=0, key_valid=0, key_held=0, multi_key=0.
  - Row synchronizer = 4'b1111; tick counter=0, column index=0; debounce count=0; candidate=NONE; state=IDLE.
- RST low mid-scan or mid-press aborts everything. After release, a held key must pass a full debounce before it is reported.
- row_in passes through a 2-flop synchronizer before any use.
- Tick counter runs 0..SCAN_DIV-1 and wraps. The wrap cycle is the "tick".
- On tick:
  - Sample the synchronized rows for the current column.
  - Then advance the column index 0->1->2->3->0. col_out = ~(1<<col_idx).
- Per-scan accumulator:
  - Counts pressed positions, saturating at 2.
  - Records the code of the first pressed position, scanning columns ascending and rows ascending within a column.
- At the tick that ends column 3, the full-scan result is NONE, SINGLE(code) or MULTI.
  - Result equal to candidate (kind and code): debounce count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: candidate=result, debounce count=1.
  - Accumulator clears for the next scan.
- A candidate is "stable" in the cycle its count first reaches DEBOUNCE_SCANS. Evaluation happens only on that transition.
- State machine, states IDLE, PRESSED, BLOCKED:
  - IDLE + stable SINGLE(c): keyin<=c, key_valid pulses for exactly one cycle (the cycle after the scan-end tick), key_held<=1, go to PRESSED.
  - IDLE + stable MULTI: multi_key<=1, go to BLOCKED, no pulse.
  - PRESSED + stable NONE: key_held<=0, go to IDLE.
  - PRESSED + stable SINGLE(c') with c' != c (rollover): no pulse, keyin unchanged, key_held stays 1, remain PRESSED. A release is required before the next event.
  - PRESSED + stable MULTI: key_held<=0, multi_key<=1, go to BLOCKED.
  - BLOCKED + stable NONE: multi_key<=0, go to IDLE.
  - BLOCKED + stable SINGLE: no pulse, stay BLOCKED.
  - IDLE + stable NONE: no action.
- key_valid is never high for two consecutive cycles. keyin changes only in the cycle key_valid rises.
- Latency: key pressed and settled before a scan starts -> key_valid asserts 1 cycle after the end-of-scan tick of the DEBOUNCE_SCANS-th consecutive identical scan. With defaults: 4 scans x 4 cols x 25000 = 400000 CLK plus up to one partial scan.
- A bounce in any scan resets the count to 1, so acceptance is delayed by DEBOUNCE_SCANS full scans from the last disturbance.

Decomposition:
- Package keypad_pkg:
  - state enum {IDLE, PRESSED, BLOCKED}
  - scan-result kind enum {NONE, SINGLE, MULTI}
  - KEY_W=4, NUM_COLS=4, NUM_ROWS=4
  - COL_IDLE=4'b1110 reset constant
- Sub-module keypad_debounce:
  - Inputs: scan-end strobe and scan result (kind + code).
  - Outputs: candidate and a one-cycle "stable" strobe.
  - Holds the candidate compare and saturating counter.
- The top holds the tick counter, column drive, synchronizer, accumulator and state machine.

Test Plan:
- Reset: hold RST low, row_in=4'hF -> col_out=4'b1110, all outputs 0. Release -> col_out sequence 1110,1101,1011,0111 every SCAN_DIV cycles, repeating.
- Single press (SCAN_DIV=4, DEBOUNCE_SCANS=2): model key row 2 / col 1 (row_in[2]=0 only while col_out[1]=0) held -> exactly one key_valid pulse, keyin=4'h9, key_held=1. Release for 2 scans -> key_held=0, no pulse.
- Bounce: toggle the key every scan for 6 scans, then hold -> no pulse during toggling; one pulse 2 full scans after the hold begins.
- Multi-key: press row0/col0 and row3/col3 together -> multi_key=1, no pulse, keyin unchanged. Release -> multi_key=0. Then press row0/col2 -> pulse, keyin=4'h2.
- Rollover: hold key 4'h5, then while held switch to 4'hA -> no second pulse, keyin stays 4'h5. Release, then press 4'hA -> pulse, keyin=4'hA.
- Async reset mid-press: assert RST low with key 4'h3 held after acceptance -> outputs clear immediately without waiting for CLK. Release RST with key still held -> fresh pulse after DEBOUNCE_SCANS scans.
